// File: rtl/fb_fill.sv
// Frame-buffer fill engine: writes a constant two-pixel word over a linear
// word range using AXI4 INCR write bursts, one burst outstanding at a time.
module fb_fill #(
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_MAX_BEATS        = 16
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [27:0]                       DRAWADDR,
   input  logic [19:0]                       DRAWLEN,
   input  logic [15:0]                       DRAWCOLOR,
   input  logic                              DRAWSTART,
   input  logic                              CLRDONE,
   output logic                              DRAWBUSY,
   output logic                              DRAWDONE,
   output logic                              DRAWERR,
   output logic                              M_AXI_AWID,
   output logic [31:0]                       M_AXI_AWADDR,
   output logic [7:0]                        M_AXI_AWLEN,
   output logic [2:0]                        M_AXI_AWSIZE,
   output logic [1:0]                        M_AXI_AWBURST,
   output logic                              M_AXI_AWLOCK,
   output logic [3:0]                        M_AXI_AWCACHE,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic [3:0]                        M_AXI_AWQOS,
   output logic                              M_AXI_AWUSER,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WLAST,
   output logic                              M_AXI_WUSER,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic                              M_AXI_BID,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BUSER,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY
);

   localparam int unsigned LOG2   = $clog2(C_MAX_BEATS);
   localparam int unsigned BEAT_W = LOG2 + 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t              state_q, state_d;
   logic [27:0]         addr_q, addr_d;
   logic [19:0]         rem_q, rem_d;
   logic [15:0]         color_q, color_d;
   logic [BEAT_W-1:0]   beats_q, beats_d;
   logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic [BEAT_W-1:0]   room;
   logic [31:0]         awaddr_q, awaddr_d;
   logic [7:0]          awlen_q, awlen_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                wlast_q, wlast_d;
   logic                bready_q, bready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                last_burst;
   logic                unused_ok;

   assign unused_ok     = ^{M_AXI_BID, M_AXI_BUSER, DRAWADDR[1:0]};
   assign last_burst    = (rem_q == 20'(beats_q));

   // Fixed AXI attributes: 32-bit INCR bursts, full strobes
   assign M_AXI_AWID    = 1'b0;
   assign M_AXI_AWSIZE  = 3'b010;
   assign M_AXI_AWBURST = 2'b01;
   assign M_AXI_AWLOCK  = 1'b0;
   assign M_AXI_AWCACHE = 4'b0011;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWQOS   = 4'b0000;
   assign M_AXI_AWUSER  = 1'b0;
   assign M_AXI_WUSER   = 1'b0;
   assign M_AXI_WSTRB   = '1;

   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWLEN   = awlen_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = {color_q, color_q};
   assign M_AXI_WLAST   = wlast_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign DRAWBUSY      = busy_q;
   assign DRAWDONE      = done_q;
   assign DRAWERR       = err_q;

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; a busy IDLE only occurs for a zero-length fill
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (!busy_q && DRAWSTART && (DRAWLEN != 20'd0)) state_d = ADDR;
         ADDR: if (M_AXI_AWREADY) state_d = DATA;
         DATA: if (wvalid_q && M_AXI_WREADY && wlast_q) state_d = RESP;
         RESP: if (M_AXI_BVALID) state_d = last_burst ? IDLE : ADDR;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      addr_d     = addr_q;
      rem_d      = rem_q;
      color_d    = color_q;
      beats_d    = beats_q;
      beat_cnt_d = beat_cnt_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;

      if (CLRDONE) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else if (DRAWSTART) begin
               addr_d  = {DRAWADDR[27:2], 2'b00};
               rem_d   = DRAWLEN;
               color_d = DRAWCOLOR;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         DATA: if (wvalid_q && M_AXI_WREADY) beat_cnt_d = beat_cnt_q + BEAT_W'(1);
         RESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
               addr_d = addr_q + 28'({beats_q, 2'b00});
               rem_d  = rem_q - 20'(beats_q);
               if (last_burst) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end
            end
         end
         default: ;
      endcase

      // Burst size limited by distance to the next C_MAX_BEATS-word boundary
      room = BEAT_W'(C_MAX_BEATS) - BEAT_W'(addr_d[2 +: LOG2]);
      if ((state_d == ADDR) && (state_q != ADDR)) begin
         beats_d    = (rem_d < 20'(room)) ? BEAT_W'(rem_d) : room;
         beat_cnt_d = '0;
         awaddr_d   = {4'b0000, addr_d[27:2], 2'b00};
         awlen_d    = 8'(beats_d - BEAT_W'(1));
      end

      awvalid_d = (state_d == ADDR);
      wvalid_d  = (state_d == DATA);
      wlast_d   = (state_d == DATA) && (beat_cnt_d == (beats_d - BEAT_W'(1)));
      bready_d  = (state_d == RESP);
   end

   // Datapath and output registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         addr_q     <= '0;
         rem_q      <= '0;
         color_q    <= '0;
         beats_q    <= '0;
         beat_cnt_q <= '0;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wlast_q    <= 1'b0;
         bready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         color_q    <= color_d;
         beats_q    <= beats_d;
         beat_cnt_q <= beat_cnt_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         wlast_q    <= wlast_d;
         bready_q   <= bready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_fb_fill.sv
// Bench for fb_fill: AXI write slave with RAM, AW scoreboard, stall injection.
module tb_fb_fill;

   localparam int MAXB = 16;
   localparam int WMASK = 32'h03FF_FFFF;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [27:0] DRAWADDR;
   logic [19:0] DRAWLEN;
   logic [15:0] DRAWCOLOR;
   logic        DRAWSTART, CLRDONE;
   logic        DRAWBUSY, DRAWDONE, DRAWERR;
   logic        M_AXI_AWID;
   logic [31:0] M_AXI_AWADDR;
   logic [7:0]  M_AXI_AWLEN;
   logic [2:0]  M_AXI_AWSIZE;
   logic [1:0]  M_AXI_AWBURST;
   logic        M_AXI_AWLOCK;
   logic [3:0]  M_AXI_AWCACHE;
   logic [2:0]  M_AXI_AWPROT;
   logic [3:0]  M_AXI_AWQOS;
   logic        M_AXI_AWUSER, M_AXI_AWVALID, M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WLAST, M_AXI_WUSER, M_AXI_WVALID, M_AXI_WREADY;
   logic        M_AXI_BID;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BUSER, M_AXI_BVALID, M_AXI_BREADY;

   fb_fill #(.C_M_AXI_DATA_WIDTH(32), .C_MAX_BEATS(MAXB)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .DRAWADDR(DRAWADDR), .DRAWLEN(DRAWLEN), .DRAWCOLOR(DRAWCOLOR),
      .DRAWSTART(DRAWSTART), .CLRDONE(CLRDONE),
      .DRAWBUSY(DRAWBUSY), .DRAWDONE(DRAWDONE), .DRAWERR(DRAWERR),
      .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
      .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
      .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
      .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
      .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
      .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   aw_t         sb_q[$];
   logic [31:0] mem [int];
   int          n_checks = 0;
   int          n_errors = 0;

   bit          stall_mode = 0;
   int          err_burst = -1;
   int          burst_idx = 0;
   int          aw_count = 0;
   logic [31:0] exp_wdata = '0;

   bit          aw_pend = 0;
   int          w_ptr = 0;
   int          w_cnt = 0;
   int          cur_len = 0;
   bit          b_pend = 0;
   bit          b_hs = 0;
   int          b_wait = 0;

   bit          aw_hold = 0;
   bit          w_hold = 0;
   logic [31:0] aw_hold_addr, w_hold_data;
   logic [7:0]  aw_hold_len;
   logic        w_hold_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slave observer: handshakes are decided by values stable at the falling edge
   initial begin
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            aw_pend = 0; b_pend = 0; b_hs = 0; aw_hold = 0; w_hold = 0;
            sb_q.delete();
         end else begin
            if (aw_hold) begin
               check("aw_hold_valid", M_AXI_AWVALID, 1);
               check("aw_hold_addr", M_AXI_AWADDR, aw_hold_addr);
               check("aw_hold_len", M_AXI_AWLEN, aw_hold_len);
            end
            aw_hold = M_AXI_AWVALID && !M_AXI_AWREADY;
            aw_hold_addr = M_AXI_AWADDR;
            aw_hold_len = M_AXI_AWLEN;
            if (w_hold) begin
               check("w_hold_valid", M_AXI_WVALID, 1);
               check("w_hold_data", M_AXI_WDATA, w_hold_data);
               check("w_hold_last", M_AXI_WLAST, w_hold_last);
            end
            w_hold = M_AXI_WVALID && !M_AXI_WREADY;
            w_hold_data = M_AXI_WDATA;
            w_hold_last = M_AXI_WLAST;

            if (M_AXI_WVALID) check("w_after_aw", aw_pend, 1);
            if (M_AXI_WVALID && M_AXI_WREADY) begin
               mem[w_ptr] = M_AXI_WDATA;
               check("wdata", M_AXI_WDATA, exp_wdata);
               check("wlast", M_AXI_WLAST, w_cnt == cur_len);
               w_ptr = (w_ptr + 1) & WMASK;
               w_cnt++;
               if (M_AXI_WLAST) begin
                  aw_pend = 0;
                  b_pend = 1;
                  b_wait = stall_mode ? int'($urandom_range(0, 5)) : 0;
               end
            end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
               aw_count++;
               if (sb_q.size() == 0) check("aw_unexpected", 1, 0);
               else begin
                  aw_t e;
                  e = sb_q.pop_front();
                  check("awaddr", M_AXI_AWADDR, e.addr);
                  check("awlen", M_AXI_AWLEN, e.len);
               end
               aw_pend = 1;
               w_ptr = int'(M_AXI_AWADDR >> 2) & WMASK;
               w_cnt = 0;
               cur_len = int'(M_AXI_AWLEN);
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
               b_hs = 1;
               burst_idx++;
            end
         end
      end
   end

   // Slave driver: updates ready/response just after each rising edge
   initial begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
      M_AXI_BRESP = 2'b00; M_AXI_BID = 0; M_AXI_BUSER = 0;
      forever begin
         @(posedge ACLK); #1;
         if (!ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
         end else begin
            M_AXI_AWREADY = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
            M_AXI_WREADY  = stall_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (b_hs) begin
               M_AXI_BVALID = 0;
               b_hs = 0;
            end
            if (b_pend && !M_AXI_BVALID) begin
               if (b_wait == 0) begin
                  M_AXI_BVALID = 1;
                  M_AXI_BRESP = (burst_idx == err_burst) ? 2'b10 : 2'b00;
                  b_pend = 0;
               end else b_wait--;
            end
         end
      end
   end

   // Reference burst split: never cross a MAXB-word boundary
   task automatic push_bursts(input logic [27:0] a, input int len, output int nb);
      int wa, rem, room, b;
      aw_t e;
      wa = int'(a >> 2);
      rem = len;
      nb = 0;
      while (rem > 0) begin
         room = MAXB - (wa % MAXB);
         b = (rem < room) ? rem : room;
         e.addr = 32'(wa) << 2;
         e.len = 8'(b - 1);
         sb_q.push_back(e);
         wa = (wa + b) & WMASK;
         rem -= b;
         nb++;
      end
   endtask

   task automatic pulse_start(input logic [27:0] a, input int len, input logic [15:0] col);
      @(posedge ACLK); #1;
      DRAWADDR = a; DRAWLEN = 20'(len); DRAWCOLOR = col; DRAWSTART = 1;
      @(posedge ACLK); #1;
      DRAWSTART = 0;
   endtask

   task automatic do_fill(input logic [27:0] a, input int len, input logic [15:0] col,
                          input bit stall, input int errb, input bit clr_end, input bit poke);
      int nb, t, budget, aw0, wa, idx;
      logic [31:0] got;
      mem.delete();
      stall_mode = stall;
      err_burst = errb;
      burst_idx = 0;
      exp_wdata = {col, col};
      push_bursts(a, len, nb);
      aw0 = aw_count;
      budget = len * 10 + 200;
      pulse_start(a, len, col);
      if (len != 0) check("first_awvalid", M_AXI_AWVALID, 1);
      check("busy_at_start", DRAWBUSY, 1);
      check("done_cleared", DRAWDONE, 0);
      check("err_cleared", DRAWERR, 0);
      if (poke) begin
         repeat (3) @(posedge ACLK);
         #1;
         DRAWADDR = 28'h800; DRAWLEN = 20'd5; DRAWCOLOR = 16'h0123; DRAWSTART = 1;
         @(posedge ACLK); #1;
         DRAWSTART = 0;
      end
      if (clr_end) CLRDONE = 1;
      t = 0;
      while (!DRAWDONE && t < budget) begin
         @(negedge ACLK);
         t++;
      end
      CLRDONE = 0;
      check("done_in_time", t < budget, 1);
      if (len == 0) begin
         check("zero_len_latency", t, 2);
         check("zero_len_no_aw", aw_count - aw0, 0);
      end
      check("done", DRAWDONE, 1);
      check("busy_end", DRAWBUSY, 0);
      check("err", DRAWERR, (errb >= 0) && (errb < nb));
      check("bursts_left", sb_q.size(), 0);
      check("burst_count", aw_count - aw0, nb);
      check("ram_words", mem.size(), len);
      wa = int'(a >> 2);
      for (int i = 0; i < len; i++) begin
         idx = (wa + i) & WMASK;
         got = mem.exists(idx) ? mem[idx] : 32'hDEAD_BEEF;
         check("ram", got, {col, col});
      end
      check("ram_after", mem.exists((wa + len) & WMASK), 0);
   endtask

   initial begin
      int t;
      int nb;
      ARESETN = 0; DRAWADDR = '0; DRAWLEN = '0; DRAWCOLOR = '0; DRAWSTART = 0; CLRDONE = 0;
      #23;
      check("rst_awvalid", M_AXI_AWVALID, 0);
      check("rst_wvalid", M_AXI_WVALID, 0);
      check("rst_wlast", M_AXI_WLAST, 0);
      check("rst_bready", M_AXI_BREADY, 0);
      check("rst_busy", DRAWBUSY, 0);
      check("rst_done", DRAWDONE, 0);
      check("rst_err", DRAWERR, 0);
      check("awsize", M_AXI_AWSIZE, 3'b010);
      check("awburst", M_AXI_AWBURST, 2'b01);
      check("awcache", M_AXI_AWCACHE, 4'b0011);
      check("wstrb", M_AXI_WSTRB, 4'hF);
      check("const_zero", {M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWPROT, M_AXI_AWQOS,
                           M_AXI_AWUSER, M_AXI_WUSER}, 0);
      ARESETN = 1;
      repeat (3) @(posedge ACLK);
      #1;
      check("idle_after_rst", {M_AXI_AWVALID, M_AXI_WVALID, DRAWBUSY, DRAWDONE}, 0);

      do_fill(28'h0, 48, 16'h0F00, 0, -1, 0, 0);
      do_fill(28'h38, 20, 16'h00F0, 0, -1, 0, 0);
      do_fill(28'h107, 37, 16'h0ABC, 1, -1, 0, 0);
      do_fill(28'h0, 0, 16'h0111, 0, -1, 0, 0);
      do_fill(28'h0, 48, 16'h0F00, 0, -1, 0, 1);
      do_fill(28'h0, 48, 16'h0555, 0, 1, 0, 0);

      @(posedge ACLK); #1;
      CLRDONE = 1;
      @(posedge ACLK); #1;
      CLRDONE = 0;
      check("clr_done", DRAWDONE, 0);
      check("clr_err", DRAWERR, 0);

      do_fill(28'hFFFFFF8, 6, 16'h0777, 1, -1, 0, 0);
      do_fill(28'h40, 200, 16'h0F0F, 0, -1, 1, 0);

      // Reset while the data phase is running
      push_bursts(28'h0, 48, nb);
      exp_wdata = 32'h0F000F00;
      stall_mode = 0;
      err_burst = -1;
      pulse_start(28'h0, 48, 16'h0F00);
      t = 0;
      while (!M_AXI_WVALID && t < 100) begin
         @(negedge ACLK);
         t++;
      end
      check("reached_data", M_AXI_WVALID, 1);
      @(posedge ACLK); #3;
      ARESETN = 0;
      #1;
      check("rst_mid_awvalid", M_AXI_AWVALID, 0);
      check("rst_mid_wvalid", M_AXI_WVALID, 0);
      check("rst_mid_wlast", M_AXI_WLAST, 0);
      check("rst_mid_bready", M_AXI_BREADY, 0);
      check("rst_mid_busy", DRAWBUSY, 0);
      repeat (2) @(posedge ACLK);
      #3;
      ARESETN = 1;
      repeat (3) @(posedge ACLK);
      #1;
      check("quiet_after_rst", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, DRAWBUSY, DRAWDONE}, 0);
      do_fill(28'h10, 30, 16'h0123, 1, -1, 0, 0);
      do_fill(28'h0, 4000, 16'h0FFF, 0, -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fb_fill.md
FB_FILL -- requirements
Module: fb_fill

Interface
REQ-001 Parameter C_M_AXI_DATA_WIDTH, default 32: AXI data width; only 32 is supported.
REQ-002 Parameter C_MAX_BEATS, default 16: maximum beats per burst; must be a power of two, 2..16.
REQ-003 ACLK  in  1  single clock for all logic.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 DRAWADDR  in  28  byte start address; bits [1:0] are ignored (word aligned).
REQ-006 DRAWLEN  in  20  number of 32-bit words to fill (0..1048575).
REQ-007 DRAWCOLOR  in  16  RGB444 pixel in bits [11:0]; bits [15:12] are written as given.
REQ-008 DRAWSTART  in  1  one-cycle start pulse.
REQ-009 CLRDONE  in  1  clears DRAWDONE and DRAWERR.
REQ-010 DRAWBUSY  out  1  fill in progress.
REQ-011 DRAWDONE  out  1  sticky: fill complete.
REQ-012 DRAWERR  out  1  sticky: any BRESP != OKAY during the fill.
REQ-013 AXI4 write master ports, with the following widths:
- M_AXI_AWID 1; M_AXI_AWADDR 32; M_AXI_AWLEN 8; M_AXI_AWSIZE 3; M_AXI_AWBURST 2; M_AXI_AWLOCK 1.
- M_AXI_AWCACHE 4; M_AXI_AWPROT 3; M_AXI_AWQOS 4; M_AXI_AWUSER 1; M_AXI_AWVALID out; M_AXI_AWREADY in.
- M_AXI_WDATA 32; M_AXI_WSTRB 4; M_AXI_WLAST; M_AXI_WUSER; M_AXI_WVALID out; M_AXI_WREADY in.
- M_AXI_BID in 1; M_AXI_BRESP in 2; M_AXI_BUSER in 1; M_AXI_BVALID in; M_AXI_BREADY out.
- There is no read channel.

Function
REQ-014 Constant outputs SHALL be:
- AWID=0, AWSIZE=3'b010, AWBURST=2'b01 (INCR), AWLOCK=0, AWCACHE=4'b0011.
- AWPROT=0, AWQOS=0, AWUSER=0, WUSER=0, WSTRB=4'hF.
REQ-015 WDATA SHALL be {DRAWCOLOR, DRAWCOLOR} as latched at start, i.e. two pixels per word.
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, RESP; exactly one burst is outstanding at a time.
REQ-017 IDLE: when DRAWSTART=1, latch address, length and color; set DRAWBUSY=1 and clear DRAWDONE and DRAWERR.
- If DRAWLEN=0, return to IDLE and set DRAWDONE=1 on the next cycle with no AXI traffic.
- Otherwise go to ADDR.
REQ-018 The burst beat count SHALL be beats = min(C_MAX_BEATS - addr_word[log2(C_MAX_BEATS)-1:0], remaining).
- As a result, bursts never cross a C_MAX_BEATS*4-byte boundary, and therefore never cross a 4 KB boundary.
- AWLEN = beats-1.
REQ-019 ADDR: AWVALID=1 with AWADDR={4'b0, cur_addr[27:2], 2'b00}.
- AWVALID and AWADDR SHALL hold stable until AWREADY=1.
- On the handshake, go to DATA.
REQ-020 DATA: WVALID=1 continuously.
- The beat counter advances only on WVALID&WREADY.
- WLAST=1 exactly on beat beats-1.
- After the WLAST handshake, go to RESP.
- WVALID SHALL NOT assert before the AW handshake.
REQ-021 RESP: BREADY=1.
- On BVALID, set DRAWERR if BRESP != 2'b00.
- Add beats*4 to cur_addr (28-bit wrap) and subtract beats from remaining.
- If remaining becomes 0, go to IDLE, deassert DRAWBUSY and set DRAWDONE in the same cycle; otherwise go to ADDR.
REQ-022 DRAWSTART SHALL be ignored while DRAWBUSY=1.
REQ-023 If CLRDONE and completion occur in the same cycle, completion wins and DRAWDONE=1.
REQ-024 A bad BRESP SHALL NOT abort the fill; the remaining bursts still execute.
REQ-025 Address wrap past 28'hFFFFFFC SHALL continue at 0 without error.
REQ-026 The first AWVALID SHALL be asserted 1 cycle after the DRAWSTART cycle.
- With zero-wait-state slave handshakes, a burst of N beats and 1-cycle BVALID latency, consecutive AW handshakes SHALL be N+3 cycles apart.

Reset
REQ-027 ARESETN=0 SHALL immediately force:
- state=IDLE;
- AWVALID=0, WVALID=0, WLAST=0, BREADY=0;
- DRAWBUSY=0, DRAWDONE=0, DRAWERR=0;
- all internal counters to 0.
REQ-028 Reset during a burst SHALL abandon the burst with no further AXI outputs asserted; the slave is reset by the same ARESETN.
REQ-029 After ARESETN rises, no output SHALL change until DRAWSTART is asserted.

Verification
REQ-030 ADDR=0, LEN=48, COLOR=16'h0F00 -> 3 bursts with AWADDR 0x00/0x40/0x80 and AWLEN=15 each; RAM words 0..47 = 32'h0F000F00; then DRAWDONE=1 and DRAWBUSY=0.
REQ-031 ADDR=0x38, LEN=20 -> bursts (0x38, AWLEN=1), (0x40, AWLEN=15), (0x80, AWLEN=1); no 64-byte boundary is crossed.
REQ-032 Full XGA fill: ADDR=0, LEN=393216, COLOR=16'h0FFF -> 24576 bursts; every word = 32'h0FFF0FFF; the word at index 393216 is unchanged.
REQ-033 Slave with random AWREADY/WREADY/BVALID stalls (0-5 cycles) -> identical RAM contents; AWADDR, AWLEN, WDATA and WLAST held stable while VALID=1 and READY=0.
REQ-034 LEN=0 -> DONE one cycle after start with no AWVALID; DRAWSTART while busy -> ignored; BRESP=2'b10 on burst 2 of 3 -> DRAWERR=1 and all 3 bursts complete.
REQ-035 ARESETN pulled low during the DATA phase -> all VALIDs drop the same cycle; a new DRAWSTART after reset completes normally.
